// File: rtl/booth_seq_controller.sv
// booth_seq_controller
//   Control FSM and I/O buffer for a 16-bit radix-2 Booth sequential multiplier.
//   Accepts an operand pair, steps the datapath through load and 16 add/sub+shift
//   iterations, then holds the 32-bit signed product on a valid/ready output.
//
//   Handshake semantics (both ports): a transfer happens on a rising clk edge
//   where valid && ready are both 1. A valid producer keeps valid and data
//   stable until that transfer; ready may be asserted with or without valid
//   and has no effect without it.
//
//   Optional feature: define BOOTH_CTRL_OPCNT_EN to add the op_count output,
//   a wrapping 16-bit count of completed output handshakes.
module booth_seq_controller #(
    parameter int WIDTH_M = 16,
    parameter int WIDTH_P = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_M-1:0] in_multiplier,
    input  logic [WIDTH_M-1:0] in_multiplicand,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_P-1:0] res_product,
    output logic [WIDTH_M-1:0] dp_multiplier,
    output logic [WIDTH_M-1:0] dp_multiplicand,
    output logic               dp_start,
    output logic               dp_en_multr,
    output logic               dp_en_mltd,
    output logic               dp_en_count,
    output logic               dp_en_ac,
    output logic               dp_selQ,
    output logic               dp_selA,
    output logic               dp_selQ_1,
    output logic               dp_en_out,
    output logic               dp_clear,
    output logic [1:0]         dp_alu_op,
    input  logic               dp_count_done,
    input  logic               dp_Q0,
    input  logic               dp_Q_1,
    input  logic [WIDTH_P-1:0] dp_product,
    output logic [1:0]         dbg_state
`ifdef BOOTH_CTRL_OPCNT_EN
    ,
    output logic [15:0]        op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   prod_load;

    // Operands go straight through; the datapath registers them on accept.
    assign dp_multiplier   = in_multiplier;
    assign dp_multiplicand = in_multiplicand;
    assign dbg_state       = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        prod_load   = 1'b0;
        dp_start    = 1'b0;
        dp_en_multr = 1'b0;
        dp_en_mltd  = 1'b0;
        dp_en_count = 1'b0;
        dp_en_ac    = 1'b0;
        dp_selQ     = 1'b0;
        dp_selA     = 1'b0;
        dp_selQ_1   = 1'b0;
        dp_en_out   = 1'b1;
        dp_clear    = 1'b0;
        dp_alu_op   = 2'b00;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Load M and Q from the inputs, zero A, restart the count.
                    dp_start    = 1'b1;
                    dp_en_mltd  = 1'b1;
                    dp_en_multr = 1'b1;
                    dp_selQ     = 1'b0;
                    dp_en_ac    = 1'b1;
                    dp_selA     = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (!dp_count_done) begin
                    dp_en_ac    = 1'b1;
                    dp_en_multr = 1'b1;
                    dp_en_count = 1'b1;
                    dp_selA     = 1'b1;
                    dp_selQ     = 1'b1;
                    dp_selQ_1   = 1'b1;
                    dp_en_out   = 1'b0;
                    prod_load   = 1'b1;
                    // Booth recoding of the {Q0, Q_-1} pair.
                    case ({dp_Q0, dp_Q_1})
                        2'b01:   dp_alu_op = 2'b01;
                        2'b10:   dp_alu_op = 2'b10;
                        default: dp_alu_op = 2'b00;
                    endcase
                end else begin
                    // Count reached: the 16th iteration's value is already held.
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    dp_clear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Product buffer: tracks the shifted {A,Q} during iterations, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_product <= '0;
        end else if (prod_load) begin
            res_product <= dp_product;
        end
    end

`ifdef BOOTH_CTRL_OPCNT_EN
    // Completed-result counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 16'd0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_seq_controller.sv
// tb_booth_seq_controller
//   Drives booth_seq_controller together with a behavioural Booth datapath
//   model, checks control timing and compares products against plain signed
//   multiplication. Define BOOTH_CTRL_OPCNT_EN to also check op_count.
module tb_booth_seq_controller;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_multiplier;
    logic [15:0] in_multiplicand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_product;
    logic [15:0] dp_multiplier;
    logic [15:0] dp_multiplicand;
    logic        dp_start, dp_en_multr, dp_en_mltd, dp_en_count, dp_en_ac;
    logic        dp_selQ, dp_selA, dp_selQ_1, dp_en_out, dp_clear;
    logic [1:0]  dp_alu_op;
    logic        dp_count_done;
    logic        dp_Q0, dp_Q_1;
    logic [31:0] dp_product;
    logic [1:0]  dbg_state;
`ifdef BOOTH_CTRL_OPCNT_EN
    logic [15:0] op_count;
`endif

    booth_seq_controller #(.WIDTH_M(16), .WIDTH_P(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplier   (in_multiplier),
        .in_multiplicand (in_multiplicand),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .res_product     (res_product),
        .dp_multiplier   (dp_multiplier),
        .dp_multiplicand (dp_multiplicand),
        .dp_start        (dp_start),
        .dp_en_multr     (dp_en_multr),
        .dp_en_mltd      (dp_en_mltd),
        .dp_en_count     (dp_en_count),
        .dp_en_ac        (dp_en_ac),
        .dp_selQ         (dp_selQ),
        .dp_selA         (dp_selA),
        .dp_selQ_1       (dp_selQ_1),
        .dp_en_out       (dp_en_out),
        .dp_clear        (dp_clear),
        .dp_alu_op       (dp_alu_op),
        .dp_count_done   (dp_count_done),
        .dp_Q0           (dp_Q0),
        .dp_Q_1          (dp_Q_1),
        .dp_product      (dp_product),
        .dbg_state       (dbg_state)
`ifdef BOOTH_CTRL_OPCNT_EN
        ,
        .op_count        (op_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- datapath model ----------------
    // A is kept 17 bits wide so M = -32768 cannot overflow the accumulator.
    logic [16:0] a_reg, m_reg, alu;
    logic [15:0] q_reg;
    logic        q1_reg;
    logic [4:0]  cnt;
    logic signed [32:0] sh;

    always_comb begin
        alu = a_reg;
        case (dp_alu_op)
            2'b01:   alu = a_reg + m_reg;
            2'b10:   alu = a_reg - m_reg;
            default: alu = a_reg;
        endcase
        sh = $signed({alu, q_reg}) >>> 1;
    end

    assign dp_product    = sh[31:0];
    assign dp_Q0         = q_reg[0];
    assign dp_Q_1        = q1_reg;
    assign dp_count_done = (cnt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0; m_reg <= '0; q_reg <= '0; q1_reg <= 1'b0; cnt <= '0;
        end else if (dp_clear) begin
            a_reg <= '0; q_reg <= '0; q1_reg <= 1'b0; cnt <= '0;
        end else begin
            if (dp_start) begin
                cnt    <= '0;
                q1_reg <= 1'b0;
            end else begin
                if (dp_en_count) cnt <= cnt + 5'd1;
                if (dp_selQ_1)   q1_reg <= q_reg[0];
            end
            if (dp_en_mltd)  m_reg <= {dp_multiplicand[15], dp_multiplicand};
            if (dp_en_ac)    a_reg <= dp_selA ? sh[32:16] : 17'd0;
            if (dp_en_multr) q_reg <= dp_selQ ? sh[15:0] : dp_multiplier;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks;
    int n_errors;
    int ops_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p;
    endfunction

    // ---------------- driver ----------------
    // Called just after a negedge with the DUT idle; returns just after the
    // negedge following the output handshake.
    task automatic run_op(input logic [15:0] mr, input logic [15:0] md,
                          input logic [31:0] exp, input int hold);
        int k;
        int rdy_bad;
        int ctl_bad;
        int hold_bad;
        logic [1:0] exp_op;
        rdy_bad  = 0;
        ctl_bad  = 0;
        hold_bad = 0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_multiplier   = mr;
        in_multiplicand = md;
        in_valid        = 1'b1;
        out_ready       = (hold == 0);
        exp_q.push_back(exp);
        #1;
        check("accept_ctrl", {26'd0, dp_start, dp_en_mltd, dp_en_multr, dp_en_ac, dp_selQ, dp_selA},
              32'b111100);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 40) begin
            if (in_ready !== 1'b0) rdy_bad++;
            if (!dp_count_done) begin
                exp_op = (dp_Q0 && !dp_Q_1) ? 2'b10 : ((!dp_Q0 && dp_Q_1) ? 2'b01 : 2'b00);
                if (dp_alu_op !== exp_op || dp_en_out !== 1'b0 || dp_en_count !== 1'b1) ctl_bad++;
            end else begin
                if (dp_en_out !== 1'b1 || dp_en_ac !== 1'b0 || dp_en_count !== 1'b0) ctl_bad++;
            end
            // Source noise while busy: must be neither accepted nor sampled.
            in_multiplier   = 16'($urandom);
            in_multiplicand = 16'($urandom);
            in_valid        = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check("latency", k, 32'd18);
        check("run_in_ready_low", rdy_bad, 32'd0);
        check("run_ctrl", ctl_bad, 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_product !== exp_q[0]) hold_bad++;
            in_valid        = 1'($urandom_range(0, 1));
            in_multiplier   = 16'($urandom);
            in_multiplicand = 16'($urandom);
            @(negedge clk);
        end
        if (hold > 0) check("done_hold_stable", hold_bad, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_flags", {28'd0, out_valid, in_ready, dp_clear, dp_en_out}, 32'b1011);
        check("product", res_product, exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        ops_done++;
        check("after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
`ifdef BOOTH_CTRL_OPCNT_EN
        check("op_count", {16'd0, op_count}, 32'(ops_done[15:0]));
`endif
    endtask

    typedef struct {
        logic [15:0] mr;
        logic [15:0] md;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[11];

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        ops_done = 0;
        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000_000F, 0};
        vecs[1]  = '{16'hFFF9, 16'h0006, 32'hFFFF_FFD6, 0};
        vecs[2]  = '{16'h8000, 16'h8000, 32'h4000_0000, 2};
        vecs[3]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1};
        vecs[4]  = '{16'h7FFF, 16'h8000, 32'hC000_8000, 0};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, 3};
        vecs[6]  = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 0};
        vecs[7]  = '{16'h0000, 16'h1234, 32'h0000_0000, 0};
        vecs[8]  = '{16'h0100, 16'h0100, 32'h0001_0000, 10};
        vecs[9]  = '{16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1};
        vecs[10] = '{16'h8000, 16'h0001, 32'hFFFF_8000, 0};

        rst_n           = 1'b0;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        in_multiplier   = 16'd0;
        in_multiplicand = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_status", {30'd0, out_valid, in_ready}, 32'b01);
        check("reset_product", res_product, 32'd0);
        check("reset_ctrl", {20'd0, dp_start, dp_en_multr, dp_en_mltd, dp_en_count, dp_en_ac,
              dp_selQ, dp_selA, dp_selQ_1, dp_en_out, dp_clear, dp_alu_op}, 32'b0000_0000_1000);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, back to back.
        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].mr, vecs[v].md, vecs[v].exp, vecs[v].hold);
        end

        // Early out_ready must not shorten the operation.
        out_ready = 1'b1;
        @(negedge clk);
        run_op(16'h0009, 16'hFFFD, 32'hFFFF_FFE5, 0);

        // Abort mid-RUN: result is lost, block returns to idle.
        in_multiplier   = 16'h0005;
        in_multiplicand = 16'h0005;
        in_valid        = 1'b1;
        exp_q.push_back(32'd25);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_status", {30'd0, out_valid, in_ready}, 32'b01);
        check("abort_product", res_product, 32'd0);
        void'(exp_q.pop_back());
        ops_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", {30'd0, dbg_state}, 32'd0);
        run_op(16'h0002, 16'h0002, 32'h0000_0004, 0);

        // Abort during DONE.
        in_multiplier   = 16'h0011;
        in_multiplicand = 16'h0003;
        in_valid        = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("done_before_abort", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_done", {res_product[30:0], out_valid}, 32'd0);
        ops_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized operands against the arithmetic reference.
        for (int r = 0; r < 25; r++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (r % 5 == 0) a = 16'h8000;
            run_op(a, b, ref_mul(a, b), $urandom_range(0, 3));
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
